hex_scan_ctrl: RTL and testbench

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_ctrl_pkg.sv | 13 +
 rtl/hex_scan_ctrl_hexdriver.sv | 30 +++
 rtl/hex_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package hex_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  // All segments dark on the active-low segment bus.
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_scan_ctrl_hexdriver.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_scan_ctrl_hexdriver (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the glyph for one nibble.
  always_comb begin
    case (nib_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      4'hF:    seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display scanner with anti-ghost gaps, leading-zero
// blanking and a one-deep pending word committed only at frame boundaries.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   digit_en,
  output logic [6:0]        HEX,
  output logic [NDIG-1:0]   AN,
  output logic              frame_done
);

  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);
  localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        hex_q, hex_d;
  logic              ready_q, ready_d;
  logic              fd_q, fd_d;

  logic              tick_s;
  logic              accept_s;
  logic              frame_end_s;
  logic              lz_s;
  logic              show_on_s;
  logic [3:0]        nib_s;
  logic [6:0]        seg_s;

  assign tick_s      = (cnt_q == TICK_MAX);
  assign accept_s    = load_valid && ready_q;
  assign frame_end_s = (state_q == GAP) && tick_s && (digit_q == LAST_DIG);

  // Select the current nibble and test whether it and every higher nibble are zero.
  always_comb begin
    nib_s = 4'h0;
    lz_s  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      nib_s = (digit_q == DW'(i)) ? disp_q[4*i +: 4] : nib_s;
      lz_s  = lz_s & ((DW'(i) < digit_q) | (disp_q[4*i +: 4] == 4'h0));
    end
  end

  hex_scan_ctrl_hexdriver u_hexdriver (
    .nib_i (nib_s),
    .seg_o (seg_s)
  );

  // Pin values for the next cycle; enable and blanking inputs are used live.
  always_comb begin
    show_on_s = (state_q == SHOW) && digit_en[digit_q] &&
                !(blank_lz && (digit_q != {DW{1'b0}}) && lz_s);
    hex_d     = show_on_s ? seg_s : SEG_OFF;
    an_d      = {NDIG{1'b1}};
    for (int i = 0; i < NDIG; i++) begin
      an_d[i] = !(show_on_s && (digit_q == DW'(i)));
    end
  end

  // Scan sequencing, display/pending register management and ready/pulse generation.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          disp_d  = load_data;
          state_d = SHOW;
          digit_d = {DW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (tick_s) begin
          state_d = GAP;
        end else begin
          state_d = SHOW;
        end
      end
      GAP: begin
        if (tick_s) begin
          state_d = SHOW;
          if (digit_q == LAST_DIG) begin
            digit_d = {DW{1'b0}};
          end else begin
            digit_d = digit_q + DW'(1);
          end
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        digit_d = {DW{1'b0}};
      end
    endcase

    // The visible word only changes between frames to avoid tearing.
    if (frame_end_s && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_d;
    end

    if (accept_s && (state_q != IDLE)) begin
      pend_d       = load_data;
      pend_valid_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    ready_d = (state_d == IDLE) || !pend_valid_d;
    fd_d    = frame_end_s;
  end

  // All state and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digit_q      <= {DW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      disp_q       <= {(4*NDIG){1'b0}};
      pend_q       <= {(4*NDIG){1'b0}};
      pend_valid_q <= 1'b0;
      an_q         <= {NDIG{1'b1}};
      hex_q        <= SEG_OFF;
      ready_q      <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      ready_q      <= ready_d;
      fd_q         <= fd_d;
    end
  end

  assign HEX        = hex_q;
  assign AN         = an_q;
  assign load_ready = ready_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl (NDIG=8, DIV=4): time-based reference model,
// directed vector table, hand-written corner sequences and randomized traffic.
module tb_hex_scan_ctrl;

  localparam int NDIG  = 8;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_ready;
  logic        blank_lz = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [6:0]  HEX;
  logic [7:0]  AN;
  logic        frame_done;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: time since the word was first loaded determines everything.
  logic        m_active;
  int          m_t;
  logic [31:0] m_disp;
  logic        m_pv;
  logic [31:0] m_pend;

  logic [6:0]  seg_tab [16];

  typedef struct {
    logic [31:0] word;
    logic        blz;
    logic [7:0]  den;
    int          dig;
    logic [7:0]  exp_an;
    logic [6:0]  exp_hex;
  } vec_t;

  vec_t vecs [13];

  hex_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .digit_en   (digit_en),
    .HEX        (HEX),
    .AN         (AN),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_disp   = 32'h0;
    m_pv     = 1'b0;
    m_pend   = 32'h0;
  endtask

  // One clock: predict pins from the pre-edge model and inputs, advance model, compare.
  task automatic cycle();
    logic [7:0] ean;
    logic [6:0] ehex;
    logic       efd, erdy, acc, commit, show;
    logic [3:0] nb;
    int         ph, dg;
    ean = 8'hFF; ehex = 7'h7F; efd = 1'b0; commit = 1'b0;
    if (m_active) begin
      ph   = m_t / DIV;
      dg   = (ph / 2) % NDIG;
      show = (ph % 2) == 0;
      nb   = 4'(m_disp >> (4 * dg));
      if (show && digit_en[dg] && !(blank_lz && dg != 0 && (m_disp >> (4 * dg)) == 32'h0)) begin
        ean[dg] = 1'b0;
        ehex    = seg_tab[nb];
      end
      if ((m_t + 1) % FRAME == 0) begin
        efd    = 1'b1;
        commit = m_pv;
      end
    end
    acc = load_valid && (!m_active || !m_pv);
    if (!m_active) begin
      if (acc) begin
        m_disp = load_data; m_active = 1'b1; m_t = 0;
      end
    end else begin
      m_t++;
      if (commit) begin m_disp = m_pend; m_pv = 1'b0; end
      if (acc) begin m_pend = load_data; m_pv = 1'b1; end
    end
    erdy = !m_active || !m_pv;
    @(posedge clk);
    #2;
    chk("AN", 32'(AN), 32'(ean));
    chk("HEX", 32'(HEX), 32'(ehex));
    chk("load_ready", 32'(load_ready), 32'(erdy));
    chk("frame_done", 32'(frame_done), 32'(efd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset applied between edges; pins must react before any clock.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_AN", 32'(AN), 32'h0000_00FF);
    chk("rst_HEX", 32'(HEX), 32'h0000_007F);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd", 32'(frame_done), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    cycle();
    load_valid = 1'b0;
  endtask

  initial begin
    int fdc;
    logic [31:0] d;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    vecs[0]  = '{32'h0000_00A5, 1'b0, 8'hFF, 0, 8'hFE, 7'b0010010};
    vecs[1]  = '{32'h0000_00A5, 1'b0, 8'hFF, 1, 8'hFD, 7'b0001000};
    vecs[2]  = '{32'h0000_00A5, 1'b0, 8'hFF, 2, 8'hFB, 7'b1000000};
    vecs[3]  = '{32'h0000_00A5, 1'b1, 8'hFF, 2, 8'hFF, 7'h7F};
    vecs[4]  = '{32'h0000_00A5, 1'b1, 8'hFF, 1, 8'hFD, 7'b0001000};
    vecs[5]  = '{32'h0000_00A5, 1'b1, 8'hFF, 7, 8'hFF, 7'h7F};
    vecs[6]  = '{32'h1234_5678, 1'b0, 8'hF0, 0, 8'hFF, 7'h7F};
    vecs[7]  = '{32'h1234_5678, 1'b0, 8'hF0, 4, 8'hEF, 7'b0011001};
    vecs[8]  = '{32'h1234_5678, 1'b0, 8'hF0, 7, 8'h7F, 7'b1111001};
    vecs[9]  = '{32'h1234_5678, 1'b0, 8'hF0, 5, 8'hDF, 7'b0110000};
    vecs[10] = '{32'h0000_0000, 1'b1, 8'hFF, 0, 8'hFE, 7'b1000000};
    vecs[11] = '{32'h0F00_0000, 1'b1, 8'hFF, 5, 8'hDF, 7'b1000000};
    vecs[12] = '{32'h0F00_0000, 1'b1, 8'hFF, 7, 8'hFF, 7'h7F};

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("init_AN", 32'(AN), 32'h0000_00FF);
    chk("init_HEX", 32'(HEX), 32'h0000_007F);
    chk("init_ready", 32'(load_ready), 32'h1);
    chk("init_fd", 32'(frame_done), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(10);

    // Directed vectors: one digit of one frame per record.
    for (int v = 0; v < 13; v++) begin
      do_reset();
      blank_lz = vecs[v].blz;
      digit_en = vecs[v].den;
      load(vecs[v].word);
      run(2 * vecs[v].dig * DIV + 2);
      chk($sformatf("vec%0d_AN", v), 32'(AN), 32'(vecs[v].exp_an));
      chk($sformatf("vec%0d_HEX", v), 32'(HEX), 32'(vecs[v].exp_hex));
    end
    blank_lz = 1'b0;
    digit_en = 8'hFF;

    // Frame pulse cadence over two full frames.
    do_reset();
    load(32'h0000_00A5);
    fdc = 0;
    for (int i = 0; i < 130; i++) begin
      cycle();
      if (frame_done) fdc++;
    end
    chk("fd_count", 32'(fdc), 32'd2);

    // Mid-frame load waits for the frame boundary.
    do_reset();
    load(32'h2222_2222);
    run(20);
    load(32'h1111_1111);
    chk("pend_ready_low", 32'(load_ready), 32'h0);
    run(37);
    chk("old_frame_AN", 32'(AN), 32'h0000_007F);
    chk("old_frame_HEX", 32'(HEX), 32'(7'b0100100));
    run(8);
    chk("new_frame_AN", 32'(AN), 32'h0000_00FE);
    chk("new_frame_HEX", 32'(HEX), 32'(7'b1111001));
    chk("commit_ready", 32'(load_ready), 32'h1);

    // Word held on the commit cycle with pend full is taken one cycle later.
    do_reset();
    load(32'h2222_2222);
    run(5);
    load(32'h1111_1111);
    load_valid = 1'b1;
    load_data  = 32'h3333_3333;
    run(59);
    load_valid = 1'b0;
    run(1);
    chk("seq_f1_HEX", 32'(HEX), 32'(7'b1111001));
    chk("seq_f1_ready", 32'(load_ready), 32'h0);
    run(64);
    chk("seq_f2_HEX", 32'(HEX), 32'(7'b0110000));
    chk("seq_f2_ready", 32'(load_ready), 32'h1);

    // Reset during digit 5, then stay idle without a load.
    do_reset();
    load(32'h1234_5678);
    run(42);
    chk("pre_rst_AN", 32'(AN), 32'h0000_00DF);
    chk("pre_rst_HEX", 32'(HEX), 32'(7'b0110000));
    load_valid = 1'b0;
    do_reset();
    run(30);
    chk("post_rst_AN", 32'(AN), 32'h0000_00FF);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 500) do_reset();
      if (n % 50 == 0) blank_lz = 1'($urandom);
      if (n % 97 == 0) digit_en = 8'($urandom);
      d = $urandom;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'h0;
      end
      load_data  = d;
      load_valid = ($urandom_range(0, 29) == 0);
      cycle();
    end
    load_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
